// File: rtl/tree_layer3_builder.sv
// tree_layer3_builder: walks the Layer2 counter RAM once per Start and
// writes one saturated, pre-shifted group sum per GROUP entries into Layer3.
module tree_layer3_builder #(
   parameter int DW       = 16,
   parameter int L2_AW    = 7,
   parameter int L2_DEPTH = 128,
   parameter int GROUP    = 8,
   parameter int SHIFT    = 3,
   parameter int L3_AW    = 4
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Start,
   input  logic [L2_AW:0]   Num_Entries,
   output logic             Busy,
   output logic             Done,
   output logic             Overflow,
   output logic             L2_Rd_En,
   output logic [L2_AW-1:0] L2_Rd_Addr,
   input  logic [DW-1:0]    L2_Rd_Data,
   output logic             L3_Wr_En,
   output logic [L3_AW-1:0] L3_Wr_Addr,
   output logic [DW-1:0]    L3_Wr_Data
);

   localparam int GW = $clog2(GROUP);
   localparam logic [L2_AW:0]   DEPTH_N  = (L2_AW+1)'(L2_DEPTH);
   localparam logic [L2_AW:0]   ONE_N    = (L2_AW+1)'(1);
   localparam logic [L2_AW-1:0] ONE_A    = (L2_AW)'(1);
   localparam logic [GW-1:0]    ONE_G    = (GW)'(1);
   localparam logic [GW-1:0]    GRP_LAST = (GW)'(GROUP-1);
   localparam logic [L3_AW-1:0] ONE_L3   = (L3_AW)'(1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [L2_AW:0]   n_q, n_d;
   logic             rd_en_q, rd_en_d;
   logic [L2_AW-1:0] rd_addr_q, rd_addr_d;
   logic             rd_vld_q, rd_vld_d;
   logic [DW-1:0]    acc_q, acc_d;
   logic [GW-1:0]    grp_q, grp_d;
   logic [L2_AW:0]   ent_q, ent_d;
   logic [L3_AW-1:0] l3_idx_q, l3_idx_d;
   logic             wr_en_q, wr_en_d;
   logic [L3_AW-1:0] wr_addr_q, wr_addr_d;
   logic [DW-1:0]    wr_data_q, wr_data_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             ovf_q, ovf_d;

   logic [L2_AW:0]   n_clamp;
   logic [DW-1:0]    shifted;
   logic [DW:0]      sum;
   logic [DW-1:0]    acc_n;

   assign n_clamp = (Num_Entries > DEPTH_N) ? DEPTH_N : Num_Entries;
   assign shifted = L2_Rd_Data >> SHIFT;
   assign sum     = {1'b0, acc_q} + {1'b0, shifted};
   assign acc_n   = sum[DW] ? {DW{1'b1}} : sum[DW-1:0];

   // Next-state: read sequencing, group accumulation and pass control.
   always_comb begin
      state_d   = state_q;
      n_d       = n_q;
      rd_en_d   = rd_en_q;
      rd_addr_d = rd_addr_q;
      rd_vld_d  = rd_en_q;
      acc_d     = acc_q;
      grp_d     = grp_q;
      ent_d     = ent_q;
      l3_idx_d  = l3_idx_q;
      wr_en_d   = 1'b0;
      wr_addr_d = '0;
      wr_data_d = '0;
      busy_d    = busy_q;
      done_d    = 1'b0;
      ovf_d     = ovf_q;

      // Returning read data: fold into the group sum, flush at group or pass end.
      if (rd_vld_q) begin
         if (sum[DW]) ovf_d = 1'b1;
         ent_d = ent_q + ONE_N;
         if ((grp_q == GRP_LAST) || ((ent_q + ONE_N) == n_q)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = l3_idx_q;
            wr_data_d = acc_n;
            l3_idx_d  = l3_idx_q + ONE_L3;
            acc_d     = '0;
            grp_d     = '0;
         end else begin
            acc_d = acc_n;
            grp_d = grp_q + ONE_G;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (Start) begin
               n_d      = n_clamp;
               ovf_d    = 1'b0;
               busy_d   = 1'b1;
               acc_d    = '0;
               grp_d    = '0;
               ent_d    = '0;
               l3_idx_d = '0;
               // An empty pass has nothing to read; go straight to the drain check.
               if (n_clamp == '0) begin
                  state_d = S_DRAIN;
               end else begin
                  state_d   = S_RUN;
                  rd_en_d   = 1'b1;
                  rd_addr_d = '0;
               end
            end
         end
         S_RUN: begin
            if (({1'b0, rd_addr_q} + ONE_N) == n_q) begin
               rd_en_d   = 1'b0;
               rd_addr_d = '0;
               state_d   = S_DRAIN;
            end else begin
               rd_addr_d = rd_addr_q + ONE_A;
            end
         end
         S_DRAIN: begin
            // Last data word has been consumed once rd_vld drops; its write is now out.
            if (!rd_vld_q) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge Clk) begin
      if (!Reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Datapath and registered outputs; reset aborts any pass in flight.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         n_q       <= '0;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
         rd_vld_q  <= 1'b0;
         acc_q     <= '0;
         grp_q     <= '0;
         ent_q     <= '0;
         l3_idx_q  <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         n_q       <= n_d;
         rd_en_q   <= rd_en_d;
         rd_addr_q <= rd_addr_d;
         rd_vld_q  <= rd_vld_d;
         acc_q     <= acc_d;
         grp_q     <= grp_d;
         ent_q     <= ent_d;
         l3_idx_q  <= l3_idx_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         ovf_q     <= ovf_d;
      end
   end

   assign Busy       = busy_q;
   assign Done       = done_q;
   assign Overflow   = ovf_q;
   assign L2_Rd_En   = rd_en_q;
   assign L2_Rd_Addr = rd_addr_q;
   assign L3_Wr_En   = wr_en_q;
   assign L3_Wr_Addr = wr_addr_q;
   assign L3_Wr_Data = wr_data_q;

endmodule

// File: tb/tb_tree_layer3_builder.sv
// Directed bench for tree_layer3_builder: default build (SHIFT=3) and a
// SHIFT=0 build driven by the same control inputs, each with its own L2 RAM port.
module tb_tree_layer3_builder;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic        Start = 1'b0;
   logic [7:0]  Num_Entries = 8'd0;

   logic        busy_a, done_a, ovf_a, rd_en_a, wr_en_a;
   logic [6:0]  rd_addr_a;
   logic [3:0]  wr_addr_a;
   logic [15:0] wr_data_a, rdata_a;

   logic        busy_b, done_b, ovf_b, rd_en_b, wr_en_b;
   logic [6:0]  rd_addr_b;
   logic [3:0]  wr_addr_b;
   logic [15:0] wr_data_b, rdata_b;

   logic [15:0] mem [0:127];

   int total = 0;
   int bad   = 0;

   always #5 Clk = ~Clk;

   // Layer2 RAM models: data one cycle after the read enable.
   always @(posedge Clk) begin
      if (rd_en_a) rdata_a <= mem[rd_addr_a];
      if (rd_en_b) rdata_b <= mem[rd_addr_b];
   end

   tree_layer3_builder u_a (
      .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Num_Entries(Num_Entries),
      .Busy(busy_a), .Done(done_a), .Overflow(ovf_a),
      .L2_Rd_En(rd_en_a), .L2_Rd_Addr(rd_addr_a), .L2_Rd_Data(rdata_a),
      .L3_Wr_En(wr_en_a), .L3_Wr_Addr(wr_addr_a), .L3_Wr_Data(wr_data_a)
   );

   tree_layer3_builder #(.SHIFT(0)) u_b (
      .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Num_Entries(Num_Entries),
      .Busy(busy_b), .Done(done_b), .Overflow(ovf_b),
      .L2_Rd_En(rd_en_b), .L2_Rd_Addr(rd_addr_b), .L2_Rd_Data(rdata_b),
      .L3_Wr_En(wr_en_b), .L3_Wr_Addr(wr_addr_b), .L3_Wr_Data(wr_data_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: {overflow, saturated sum of (mem>>sh)} over group g of an n-entry pass.
   function automatic logic [16:0] grp_sum(input int g, input int n, input int sh);
      logic [16:0] s;
      logic        o;
      s = '0;
      o = 1'b0;
      for (int k = g * 8; k < n && k < g * 8 + 8; k++) begin
         s = {1'b0, s[15:0]} + {1'b0, 16'(mem[k] >> sh)};
         if (s[16]) begin
            o = 1'b1;
            s = 17'h0FFFF;
         end
      end
      return {o, s[15:0]};
   endfunction

   task automatic run_pass(input string nm, input int n_in, input int repulse);
      int n, ngrp, rd_cnt, done_a_cnt, done_b_cnt, done_cyc, exp_done, last_k;
      bit rd_ok, busy_ok, busy_exp, oa_exp, ob_exp;
      logic [16:0] ra, rb;
      logic [3:0]  wa_addr[$], wb_addr[$];
      logic [15:0] wa_data[$], wb_data[$];
      int          wa_cyc[$];
      n = (n_in > 128) ? 128 : n_in;
      ngrp = (n + 7) / 8;
      rd_cnt = 0; done_a_cnt = 0; done_b_cnt = 0; done_cyc = -1;
      rd_ok = 1'b1; busy_ok = 1'b1; oa_exp = 1'b0; ob_exp = 1'b0;
      exp_done = (n == 0) ? 2 : n + 3;
      Start = 1'b1;
      Num_Entries = 8'(n_in);
      for (int c = 1; c <= n + 6; c++) begin
         @(posedge Clk); #1;
         if (c == 1) begin
            Start = 1'b0;
            Num_Entries = 8'd3;
            chk({nm, " ovf_clr_b"}, 32'(ovf_b), 32'd0);
         end
         if (c == repulse) begin
            Start = 1'b1;
            Num_Entries = 8'd5;
         end
         if (c == repulse + 1) Start = 1'b0;
         if (rd_en_a) begin
            if (rd_addr_a !== 7'(rd_cnt) || c != rd_cnt + 1) rd_ok = 1'b0;
            rd_cnt++;
         end
         if (wr_en_a) begin
            wa_addr.push_back(wr_addr_a);
            wa_data.push_back(wr_data_a);
            wa_cyc.push_back(c);
         end
         if (wr_en_b) begin
            wb_addr.push_back(wr_addr_b);
            wb_data.push_back(wr_data_b);
         end
         busy_exp = (n == 0) ? (c == 1) : (c <= n + 2);
         if (busy_a !== busy_exp || busy_b !== busy_exp) busy_ok = 1'b0;
         if (done_a) begin
            done_a_cnt++;
            done_cyc = c;
         end
         if (done_b) done_b_cnt++;
      end
      chk({nm, " rd_count"}, 32'(rd_cnt), 32'(n));
      chk({nm, " rd_seq"}, 32'(rd_ok), 32'd1);
      chk({nm, " busy"}, 32'(busy_ok), 32'd1);
      chk({nm, " done_a_count"}, 32'(done_a_cnt), 32'd1);
      chk({nm, " done_b_count"}, 32'(done_b_cnt), 32'd1);
      chk({nm, " done_cycle"}, 32'(done_cyc), 32'(exp_done));
      chk({nm, " wr_count_a"}, 32'(wa_addr.size()), 32'(ngrp));
      chk({nm, " wr_count_b"}, 32'(wb_addr.size()), 32'(ngrp));
      for (int i = 0; i < ngrp; i++) begin
         ra = grp_sum(i, n, 3);
         rb = grp_sum(i, n, 0);
         oa_exp = oa_exp | ra[16];
         ob_exp = ob_exp | rb[16];
         last_k = (8 * i + 7 < n - 1) ? 8 * i + 7 : n - 1;
         if (i < wa_addr.size()) begin
            chk($sformatf("%s wa_addr[%0d]", nm, i), 32'(wa_addr[i]), 32'(i));
            chk($sformatf("%s wa_data[%0d]", nm, i), 32'(wa_data[i]), 32'(ra[15:0]));
            chk($sformatf("%s wa_cyc[%0d]", nm, i), 32'(wa_cyc[i]), 32'(last_k + 3));
         end
         if (i < wb_addr.size()) begin
            chk($sformatf("%s wb_addr[%0d]", nm, i), 32'(wb_addr[i]), 32'(i));
            chk($sformatf("%s wb_data[%0d]", nm, i), 32'(wb_data[i]), 32'(rb[15:0]));
         end
      end
      chk({nm, " ovf_a"}, 32'(ovf_a), 32'(oa_exp));
      chk({nm, " ovf_b"}, 32'(ovf_b), 32'(ob_exp));
      $display("pass %s: n=%0d writes_a=%0d writes_b=%0d done_cycle=%0d ovf_a=%0b ovf_b=%0b",
               nm, n, wa_addr.size(), wb_addr.size(), done_cyc, ovf_a, ovf_b);
   endtask

   initial begin
      int ev_cnt;
      for (int k = 0; k < 128; k++) mem[k] = 16'h0000;
      rdata_a = '0;
      rdata_b = '0;

      // Reset state.
      repeat (3) @(posedge Clk);
      #1;
      chk("rst busy", 32'(busy_a), 32'd0);
      chk("rst done", 32'(done_a), 32'd0);
      chk("rst ovf", 32'(ovf_a), 32'd0);
      chk("rst rd_en", 32'(rd_en_a), 32'd0);
      chk("rst wr_en", 32'(wr_en_a), 32'd0);
      chk("rst wr_data", 32'(wr_data_a), 32'd0);
      Reset_n = 1'b1;
      @(posedge Clk); #1;

      // Full depth, uniform data.
      for (int k = 0; k < 128; k++) mem[k] = 16'h0010;
      run_pass("full128", 128, -1);

      // Ramp data with a partial final group.
      for (int k = 0; k < 128; k++) mem[k] = 16'(8 * k);
      run_pass("ramp20", 20, -1);

      // Saturating data; SHIFT=0 build overflows, sticky afterwards.
      for (int k = 0; k < 128; k++) mem[k] = 16'hFFFF;
      run_pass("sat8", 8, -1);
      repeat (4) @(posedge Clk);
      #1;
      chk("sat sticky_b", 32'(ovf_b), 32'd1);
      for (int k = 0; k < 128; k++) mem[k] = 16'h0010;
      run_pass("clean8", 8, -1);

      // Empty and clamped entry counts.
      run_pass("n0", 0, -1);
      for (int k = 0; k < 128; k++) mem[k] = 16'(k * 37 + 5);
      run_pass("n200", 200, -1);

      // Start re-pulsed mid-pass is ignored.
      for (int k = 0; k < 128; k++) mem[k] = 16'(8 * k);
      run_pass("repulse", 20, 5);

      // Reset in cycle 12 of an N=20 pass aborts it.
      Start = 1'b1;
      Num_Entries = 8'd20;
      for (int c = 1; c <= 12; c++) begin
         @(posedge Clk); #1;
         if (c == 1) Start = 1'b0;
      end
      Reset_n = 1'b0;
      @(posedge Clk); #1;
      chk("abort busy", 32'(busy_a), 32'd0);
      chk("abort done", 32'(done_a), 32'd0);
      chk("abort rd_en", 32'(rd_en_a), 32'd0);
      chk("abort rd_addr", 32'(rd_addr_a), 32'd0);
      chk("abort wr_en", 32'(wr_en_a), 32'd0);
      chk("abort wr_addr", 32'(wr_addr_a), 32'd0);
      chk("abort busy_b", 32'(busy_b), 32'd0);
      Reset_n = 1'b1;
      ev_cnt = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge Clk); #1;
         if (done_a || wr_en_a || rd_en_a || busy_a) ev_cnt++;
      end
      chk("abort quiet", 32'(ev_cnt), 32'd0);
      $display("abort: reset applied in cycle 12, quiet cycles checked");
      run_pass("post_rst", 20, -1);

      // Random lengths and data against the reference sums.
      for (int r = 0; r < 4; r++) begin
         int n;
         n = int'($urandom_range(1, 128));
         for (int k = 0; k < 128; k++) mem[k] = 16'($urandom);
         run_pass($sformatf("rand%0d", r), n, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
